msk_pipe_buf: RTL and testbench

Parametrised masked elastic pipeline buffer. It generalises the masked enable-register into a DEPTH-stage, valid/ready-handshaked buffer of count × d-share sharings, with bubble collapsing, synchronous flush and an occupancy count. It sits between masked datapath blocks, such as the permutation core and the tag/output logic, where the producer and consumer stall independently. Shares are only stored, muxed per bit and cleared, never combined.

---
 rtl/msk_pipe_buf_pkg.sv | 13 +
 rtl/msk_pipe_stage.sv | 46 ++++
 rtl/msk_pipe_buf.sv | 88 ++++++++
 tb/tb_msk_pipe_buf.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/msk_pipe_buf_pkg.sv
// Shared sizing helpers for the masked elastic pipeline buffer.
// Keeps the occupancy-counter width and sharing width consistent across files.
package msk_pipe_buf_pkg;

   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int share_w(input int cnt, input int shares);
      return cnt * shares;
   endfunction

endpackage

// File: rtl/msk_pipe_stage.sv
// One masked pipeline stage: valid bit plus per-share-bit muxed register.
// Loading an invalid beat writes zero so no stale shares stay behind.
module msk_pipe_stage
   import msk_pipe_buf_pkg::*;
#(
   parameter int W = 4
) (
   (* fv_type = "clock" *)   input  logic         clk,
   (* fv_type = "control" *) input  logic         rst,
   (* fv_type = "control" *) input  logic         flush,
   (* fv_type = "control" *) input  logic         en,
   (* fv_type = "control" *) input  logic         ld_valid,
   (* fv_type = "sharing" *) input  logic [W-1:0] ld_data,
   (* fv_type = "control" *) output logic         valid,
   (* fv_type = "sharing" *) output logic [W-1:0] data
);

   logic [W-1:0] ld_masked;
   logic [W-1:0] data_nxt;
   logic         valid_nxt;

   // Each share bit gets its own mux; nothing here ever mixes two shares.
   always_comb begin
      ld_masked = '0;
      data_nxt  = '0;
      for (int b = 0; b < W; b++) begin
         ld_masked[b] = ld_data[b] & ld_valid;
         data_nxt[b]  = en ? ld_masked[b] : data[b];
      end
      valid_nxt = en ? ld_valid : valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         valid <= valid_nxt;
         data  <= data_nxt;
      end
   end

endmodule

// File: rtl/msk_pipe_buf.sv
// Masked elastic pipeline buffer: DEPTH handshaked stages with bubble
// collapsing, synchronous flush and an occupancy count.
module msk_pipe_buf
   import msk_pipe_buf_pkg::*;
#(
   parameter int d     = 2,
   parameter int count = 1,
   parameter int DEPTH = 2
) (
   (* fv_type = "clock" *)   input  logic                        clk,
   (* fv_type = "control" *) input  logic                        rst,
   (* fv_type = "control" *) input  logic                        flush,
   (* fv_type = "sharing" *) input  logic [share_w(count, d)-1:0] in_data,
   (* fv_type = "control" *) input  logic                        in_valid,
   (* fv_type = "control" *) output logic                        in_ready,
   (* fv_type = "sharing" *) output logic [share_w(count, d)-1:0] out_data,
   (* fv_type = "control" *) output logic                        out_valid,
   (* fv_type = "control" *) input  logic                        out_ready,
   (* fv_type = "control" *) output logic [occ_w(DEPTH)-1:0]     occ
);

   localparam int W     = share_w(count, d);
   localparam int OCC_W = occ_w(DEPTH);

   logic [DEPTH-1:0] stage_valid;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] ld_valid;
   logic [W-1:0]     stage_data [DEPTH];
   logic [W-1:0]     ld_data    [DEPTH];
   logic             accept;
   logic             take;

   // A stage may advance when it or any stage below it is empty, or the
   // consumer drains the last one; written flat to avoid a self-loop.
   always_comb begin
      adv = '0;
      for (int i = 0; i < DEPTH; i++) begin
         adv[i] = out_ready;
         for (int j = i; j < DEPTH; j++) begin
            if (!stage_valid[j]) adv[i] = 1'b1;
         end
      end
   end

   assign in_ready  = adv[0] && !flush;
   assign accept    = in_valid && in_ready;
   assign out_valid = stage_valid[DEPTH-1];
   assign out_data  = stage_data[DEPTH-1];
   assign take      = out_valid && out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign ld_valid[i] = accept;
         assign ld_data[i]  = in_data;
      end else begin : g_body
         assign ld_valid[i] = stage_valid[i-1];
         assign ld_data[i]  = stage_data[i-1];
      end

      msk_pipe_stage #(
         .W(W)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .en       (adv[i]),
         .ld_valid (ld_valid[i]),
         .ld_data  (ld_data[i]),
         .valid    (stage_valid[i]),
         .data     (stage_data[i])
      );
   end

   // Occupancy tracks accepted beats minus consumed ones; a simultaneous
   // push and pop cancels out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ <= '0;
      end else if (flush) begin
         occ <= '0;
      end else if (accept && !take) begin
         occ <= occ + OCC_W'(1);
      end else if (take && !accept) begin
         occ <= occ - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_msk_pipe_buf.sv
// Randomised and directed bench for msk_pipe_buf (DEPTH=3 and DEPTH=1 instances)
// against a beat-queue reference model.
module tb_msk_pipe_buf;

   localparam int DEPTH = 3;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [3:0] in_data;
   logic       in_valid;
   logic       out_ready;

   logic       in_ready;
   logic [3:0] out_data;
   logic       out_valid;
   logic [1:0] occ;

   logic       in_ready1;
   logic [3:0] out_data1;
   logic       out_valid1;
   logic [0:0] occ1;

   int n_cmp;
   int n_bad;

   // Reference model: beats in arrival order (index 0 oldest) with the stage
   // each one currently sits in.
   int         mpos[$];
   logic [3:0] mdat[$];

   // Reference model for the single-slot buffer.
   logic       r_full;
   logic [3:0] r_data;

   msk_pipe_buf #(.d(2), .count(2), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occ       (occ)
   );

   msk_pipe_buf #(.d(2), .count(2), .DEPTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .out_data  (out_data1),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .occ       (occ1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clearModel();
      mpos.delete();
      mdat.delete();
      r_full = 1'b0;
      r_data = '0;
   endtask

   // One clock cycle: drive, check against the model, then advance the model.
   task automatic applyStimulus(input logic iv, input logic [3:0] id, input logic ordy, input logic fl);
      logic       e_ov, e_ir, last_mv, take, e1_ir;
      logic [3:0] e_od;
      bit         mv[$];
      int         n;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      #3;
      n    = mpos.size();
      e_ov = (n > 0) && (mpos[0] == DEPTH - 1);
      e_od = e_ov ? mdat[0] : 4'h0;
      mv.delete();
      last_mv = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (k == 0) last_mv = (mpos[0] < DEPTH - 1) || ordy;
         else        last_mv = (mpos[k] + 1 < mpos[k-1]) || last_mv;
         mv.push_back(last_mv);
      end
      e_ir = !fl && ((n == 0) || (mpos[n-1] > 0) || last_mv);
      checkOutput("out_valid", 32'(out_valid), 32'(e_ov));
      checkOutput("out_data",  32'(out_data),  32'(e_od));
      checkOutput("occ",       32'(occ),       32'(n));
      checkOutput("in_ready",  32'(in_ready),  32'(e_ir));

      e1_ir = !fl && (!r_full || ordy);
      checkOutput("d1_out_valid", 32'(out_valid1), 32'(r_full));
      checkOutput("d1_out_data",  32'(out_data1),  32'(r_full ? r_data : 4'h0));
      checkOutput("d1_occ",       32'(occ1),       32'(r_full));
      checkOutput("d1_in_ready",  32'(in_ready1),  32'(e1_ir));

      if (fl) begin
         clearModel();
      end else begin
         take = e_ov && ordy;
         for (int k = 0; k < n; k++) if (mv[k]) mpos[k] = mpos[k] + 1;
         if (take) begin
            void'(mpos.pop_front());
            void'(mdat.pop_front());
         end
         if (iv && e_ir) begin
            mpos.push_back(0);
            mdat.push_back(id);
         end
         if (!r_full || ordy) begin
            r_full = iv && e1_ir;
            r_data = id;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clearModel();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Streaming A,5,C with the consumer always ready.
      applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'h5, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'hC, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

      // Fill under backpressure, then one simultaneous push/pop.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'(i + 3), 1'b0, 1'b0);
      applyStimulus(1'b1, 4'hE, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

      // Flush while full with a beat offered.
      applyStimulus(1'b1, 4'h9, 1'b1, 1'b1);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

      // Bubble collapse: one beat stalls at the end, a later one closes up.
      applyStimulus(1'b1, 4'h6, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

      // Asynchronous reset between edges while loaded.
      applyStimulus(1'b1, 4'hB, 1'b0, 1'b0);
      in_valid = 1'b0;
      flush    = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      clearModel();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_occ",       32'(occ),       32'd0);
      checkOutput("rst_out_data",  32'(out_data),  32'd0);
      checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
      checkOutput("rst_d1_valid",  32'(out_valid1), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random traffic with occasional flushes.
      for (int i = 0; i < 500; i++) begin
         applyStimulus(($urandom % 4) != 0, 4'($urandom), ($urandom % 5) < 3,
                       ($urandom % 25) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
